// File: rtl/decode_seq_pkg.sv
// Shared types and default constants for the decode sequencer and its timers.
package decode_seq_pkg;

  localparam int unsigned AddrW = 18;
  localparam int unsigned DataW = 16;

  localparam int unsigned DefaultUartTimeout  = 50000000;
  localparam int unsigned DefaultStageTimeout = 67108863;
  localparam int unsigned DefaultTimerW       = 26;

  // Encodings are visible on the stage output (LEDs), so they are fixed.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StUartRx = 3'd1,
    StM2     = 3'd2,
    StM1     = 3'd3,
    StAbort  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_timer.sv
// Loadable up-counter with clear/enable that saturates at its terminal count.
module seq_timer
  import decode_seq_pkg::*;
#(
  parameter int unsigned Width    = DefaultTimerW,
  parameter int unsigned Terminal = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  localparam logic [Width-1:0] TermVal = Width'(Terminal);

  logic [Width-1:0] count_q, count_d;

  assign tc_o = (count_q == TermVal);

  // Holding at the terminal count keeps the counter from ever wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Sequences UART load -> M2 -> M1 and hands the single SRAM port to the owning stage,
// returning it to VGA when idle. Each decode stage is guarded by a watchdog.
module decode_sequencer
  import decode_seq_pkg::*;
#(
  parameter int unsigned UART_TIMEOUT  = DefaultUartTimeout,
  parameter int unsigned STAGE_TIMEOUT = DefaultStageTimeout,
  parameter int unsigned TIMER_W       = DefaultTimerW
) (
  input  logic             CLOCK_50_I,
  input  logic             resetn,
  input  logic             uart_rx_i,
  input  logic             skip_decode,
  input  logic [AddrW-1:0] uart_address,
  input  logic [DataW-1:0] uart_write_data,
  input  logic             uart_we_n,
  input  logic [AddrW-1:0] m2_address,
  input  logic [DataW-1:0] m2_write_data,
  input  logic             m2_we_n,
  input  logic [AddrW-1:0] m1_address,
  input  logic [DataW-1:0] m1_write_data,
  input  logic             m1_we_n,
  input  logic [AddrW-1:0] vga_address,
  input  logic             m2_done,
  input  logic             m1_done,
  output logic             uart_rx_initialize,
  output logic             uart_rx_enable,
  output logic             m2_start,
  output logic             m1_start,
  output logic             vga_enable,
  output logic [AddrW-1:0] sram_address,
  output logic [DataW-1:0] sram_write_data,
  output logic             sram_we_n,
  output logic [2:0]       stage,
  output logic             error
);

  state_e state_q, state_d;
  logic   init_q, init_d;
  logic   rx_en_q, rx_en_d;
  logic   m2_start_q, m2_start_d;
  logic   m1_start_q, m1_start_d;
  logic   vga_en_q, vga_en_d;
  logic   error_q, error_d;
  logic   word_seen_q, word_seen_d;

  logic uart_clr, uart_en, uart_tc;
  logic stage_clr, stage_en, stage_tc;

  seq_timer #(
    .Width    (TIMER_W),
    .Terminal (UART_TIMEOUT - 1)
  ) u_uart_timer (
    .clk_i      (CLOCK_50_I),
    .rst_ni     (resetn),
    .clr_i      (uart_clr),
    .en_i       (uart_en),
    .load_i     (1'b0),
    .load_val_i ({TIMER_W{1'b0}}),
    .tc_o       (uart_tc)
  );

  seq_timer #(
    .Width    (TIMER_W),
    .Terminal (STAGE_TIMEOUT - 1)
  ) u_stage_timer (
    .clk_i      (CLOCK_50_I),
    .rst_ni     (resetn),
    .clr_i      (stage_clr),
    .en_i       (stage_en),
    .load_i     (1'b0),
    .load_val_i ({TIMER_W{1'b0}}),
    .tc_o       (stage_tc)
  );

  always_comb begin
    state_d     = state_q;
    init_d      = 1'b0;
    rx_en_d     = rx_en_q;
    m2_start_d  = m2_start_q;
    m1_start_d  = m1_start_q;
    vga_en_d    = vga_en_q;
    error_d     = error_q;
    word_seen_d = word_seen_q;
    uart_clr    = 1'b0;
    uart_en     = 1'b0;
    stage_clr   = 1'b0;
    stage_en    = 1'b0;

    case (state_q)
      StIdle: begin
        vga_en_d  = 1'b1;
        uart_clr  = 1'b1;
        stage_clr = 1'b1;
        if (!uart_rx_i) begin
          state_d     = StUartRx;
          init_d      = 1'b1;
          vga_en_d    = 1'b0;
          error_d     = 1'b0;
          word_seen_d = 1'b0;
        end
      end

      StUartRx: begin
        stage_clr = 1'b1;
        if (init_q) begin
          rx_en_d = 1'b1;
        end
        if (!uart_we_n) begin
          uart_clr    = 1'b1;
          word_seen_d = 1'b1;
        end else begin
          uart_en = 1'b1;
          if (uart_tc) begin
            rx_en_d = 1'b0;
            // A start bit with no data written is treated as line noise.
            if (word_seen_q && !skip_decode) begin
              state_d    = StM2;
              m2_start_d = 1'b1;
            end else begin
              state_d  = StIdle;
              vga_en_d = 1'b1;
            end
          end
        end
      end

      StM2: begin
        stage_en = 1'b1;
        if (m2_done) begin
          state_d    = StM1;
          m2_start_d = 1'b0;
          m1_start_d = 1'b1;
          stage_clr  = 1'b1;
        end else if (stage_tc) begin
          state_d    = StAbort;
          m2_start_d = 1'b0;
          error_d    = 1'b1;
        end
      end

      StM1: begin
        stage_en = 1'b1;
        if (m1_done) begin
          state_d    = StIdle;
          m1_start_d = 1'b0;
          vga_en_d   = 1'b1;
        end else if (stage_tc) begin
          state_d    = StAbort;
          m1_start_d = 1'b0;
          error_d    = 1'b1;
        end
      end

      StAbort: begin
        state_d  = StIdle;
        vga_en_d = 1'b1;
      end

      default: begin
        state_d    = StIdle;
        rx_en_d    = 1'b0;
        m2_start_d = 1'b0;
        m1_start_d = 1'b0;
        vga_en_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      init_q      <= 1'b0;
      rx_en_q     <= 1'b0;
      m2_start_q  <= 1'b0;
      m1_start_q  <= 1'b0;
      vga_en_q    <= 1'b1;
      error_q     <= 1'b0;
      word_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      rx_en_q     <= rx_en_d;
      m2_start_q  <= m2_start_d;
      m1_start_q  <= m1_start_d;
      vga_en_q    <= vga_en_d;
      error_q     <= error_d;
      word_seen_q <= word_seen_d;
    end
  end

  // Selected purely by registered state so request inputs cannot steer ownership.
  always_comb begin
    sram_address    = vga_address;
    sram_write_data = '0;
    sram_we_n       = 1'b1;
    case (state_q)
      StUartRx: begin
        sram_address    = uart_address;
        sram_write_data = uart_write_data;
        sram_we_n       = uart_we_n;
      end
      StM2: begin
        sram_address    = m2_address;
        sram_write_data = m2_write_data;
        sram_we_n       = m2_we_n;
      end
      StM1: begin
        sram_address    = m1_address;
        sram_write_data = m1_write_data;
        sram_we_n       = m1_we_n;
      end
      default: ;
    endcase
  end

  assign uart_rx_initialize = init_q;
  assign uart_rx_enable     = rx_en_q;
  assign m2_start           = m2_start_q;
  assign m1_start           = m1_start_q;
  assign vga_enable         = vga_en_q;
  assign error              = error_q;
  assign stage              = state_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Randomized self-checking bench for decode_sequencer with short timeouts.
module tb_decode_sequencer;

  localparam int unsigned UartTo  = 100;
  localparam int unsigned StageTo = 50;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic        skip_decode = 1'b0;
  logic [17:0] uart_address = '0, m2_address = '0, m1_address = '0, vga_address = '0;
  logic [15:0] uart_write_data = '0, m2_write_data = '0, m1_write_data = '0;
  logic        uart_we_n = 1'b1, m2_we_n = 1'b1, m1_we_n = 1'b1;
  logic        m2_done = 1'b0, m1_done = 1'b0;
  logic        uart_rx_initialize, uart_rx_enable, m2_start, m1_start, vga_enable, error;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic        sram_we_n;
  logic [2:0]  stage;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic m2_seen = 1'b0;

  decode_sequencer #(
    .UART_TIMEOUT  (UartTo),
    .STAGE_TIMEOUT (StageTo),
    .TIMER_W       (26)
  ) dut (
    .CLOCK_50_I         (clk),
    .resetn             (resetn),
    .uart_rx_i          (uart_rx_i),
    .skip_decode        (skip_decode),
    .uart_address       (uart_address),
    .uart_write_data    (uart_write_data),
    .uart_we_n          (uart_we_n),
    .m2_address         (m2_address),
    .m2_write_data      (m2_write_data),
    .m2_we_n            (m2_we_n),
    .m1_address         (m1_address),
    .m1_write_data      (m1_write_data),
    .m1_we_n            (m1_we_n),
    .vga_address        (vga_address),
    .m2_done            (m2_done),
    .m1_done            (m1_done),
    .uart_rx_initialize (uart_rx_initialize),
    .uart_rx_enable     (uart_rx_enable),
    .m2_start           (m2_start),
    .m1_start           (m1_start),
    .vga_enable         (vga_enable),
    .sram_address       (sram_address),
    .sram_write_data    (sram_write_data),
    .sram_we_n          (sram_we_n),
    .stage              (stage),
    .error              (error)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ownership table: which requester may reach SRAM in each stage.
  function automatic logic [34:0] exp_sram(input logic [2:0] st);
    case (st)
      3'd1:    return {uart_address, uart_write_data, uart_we_n};
      3'd2:    return {m2_address, m2_write_data, m2_we_n};
      3'd3:    return {m1_address, m1_write_data, m1_we_n};
      default: return {vga_address, 16'h0000, 1'b1};
    endcase
  endfunction

  always @(negedge clk) begin
    if (m2_start) m2_seen = 1'b1;
    if (resetn) begin
      checks++;
      if ({sram_address, sram_write_data, sram_we_n} !== exp_sram(stage)) begin
        errors++;
        $display("FAIL mux stage=%0d: got %h, want %h", stage,
                 {sram_address, sram_write_data, sram_we_n}, exp_sram(stage));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stage(input logic [2:0] st, input int max_cyc, output int n);
    n = 0;
    while (stage !== st && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic start_load(input int nw, output int last_w);
    last_w = cyc;
    uart_rx_i = 1'b0;
    tick();
    uart_rx_i = 1'b1;
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(3, 40)) tick();
      uart_address    = 18'($urandom);
      uart_write_data = 16'($urandom);
      uart_we_n       = 1'b0;
      tick();
      last_w    = cyc;
      uart_we_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    vga_address = 18'($urandom);
    #25;
    checks++;
    if ({uart_rx_initialize, uart_rx_enable, m2_start, m1_start, vga_enable, error, stage}
        !== {6'b000010, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b %0d, want 000010 0",
               {uart_rx_initialize, uart_rx_enable, m2_start, m1_start, vga_enable, error}, stage);
    end
    checks++;
    if ({sram_address, sram_we_n} !== {vga_address, 1'b1}) begin
      errors++;
      $display("FAIL reset_sram: got %h/%b, want %h/1", sram_address, sram_we_n, vga_address);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_idle_mux();
    for (int i = 0; i < 20; i++) begin
      vga_address  = 18'($urandom);
      uart_address = 18'($urandom);
      m2_address   = 18'($urandom);
      uart_we_n    = 1'($urandom);
      m2_we_n      = 1'($urandom);
      m1_we_n      = 1'($urandom);
      #1;
      checks++;
      if ({sram_address, sram_we_n, stage} !== {vga_address, 1'b1, 3'd0}) begin
        errors++;
        $display("FAIL idle_mux: got %h/%b st%0d, want %h/1 st0",
                 sram_address, sram_we_n, stage, vga_address);
      end
      tick();
    end
    uart_we_n = 1'b1;
    m2_we_n   = 1'b1;
    m1_we_n   = 1'b1;
  endtask

  task automatic test_load_decode();
    int last_w, n;
    skip_decode = 1'b0;
    uart_rx_i   = 1'b0;
    tick();
    uart_rx_i = 1'b1;
    checks++;
    if ({uart_rx_initialize, vga_enable, stage} !== {1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL load_init: got %b%b st%0d, want 10 st1", uart_rx_initialize, vga_enable,
               stage);
    end
    tick();
    checks++;
    if ({uart_rx_initialize, uart_rx_enable} !== 2'b01) begin
      errors++;
      $display("FAIL load_rx_enable: got %b%b, want 01", uart_rx_initialize, uart_rx_enable);
    end
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(3, 40)) tick();
      uart_address    = 18'($urandom);
      uart_write_data = 16'($urandom);
      uart_we_n       = 1'b0;
      tick();
      last_w    = cyc;
      uart_we_n = 1'b1;
    end
    wait_stage(3'd2, 300, n);
    checks++;
    if (stage !== 3'd2 || cyc - last_w != int'(UartTo)) begin
      errors++;
      $display("FAIL m2_entry: got st%0d after %0d cycles, want st2 after %0d", stage,
               cyc - last_w, UartTo);
    end
    checks++;
    if ({m2_start, m1_start, uart_rx_enable} !== 3'b100) begin
      errors++;
      $display("FAIL m2_start: got %b, want 100", {m2_start, m1_start, uart_rx_enable});
    end
    for (int i = 0; i < int'($urandom_range(5, 20)); i++) begin
      uart_we_n     = 1'($urandom);
      m1_we_n       = 1'($urandom);
      m2_we_n       = 1'($urandom);
      m2_address    = 18'($urandom);
      m2_write_data = 16'($urandom);
      m1_address    = 18'($urandom);
      #1;
      checks++;
      if ({sram_we_n, sram_address} !== {m2_we_n, m2_address}) begin
        errors++;
        $display("FAIL m2_isolation: got %b/%h, want %b/%h", sram_we_n, sram_address, m2_we_n,
                 m2_address);
      end
      tick();
    end
    uart_we_n = 1'b1;
    m1_we_n   = 1'b1;
    m2_we_n   = 1'b1;
    m2_done   = 1'b1;
    tick();
    m2_done = 1'b0;
    checks++;
    if ({stage, m2_start, m1_start} !== {3'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL m2_to_m1: got st%0d %b%b, want st3 01", stage, m2_start, m1_start);
    end
    m2_done = 1'b1;
    tick();
    m2_done = 1'b0;
    checks++;
    if ({stage, m2_start, m1_start} !== {3'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL stray_m2_done: got st%0d %b%b, want st3 01", stage, m2_start, m1_start);
    end
    repeat ($urandom_range(1, 10)) tick();
    m1_done = 1'b1;
    tick();
    m1_done = 1'b0;
    checks++;
    if ({stage, vga_enable, m1_start, error} !== {3'd0, 3'b100}) begin
      errors++;
      $display("FAIL m1_complete: got st%0d %b%b%b, want st0 100", stage, vga_enable, m1_start,
               error);
    end
  endtask

  task automatic test_spurious();
    int entry, n;
    m2_seen   = 1'b0;
    uart_rx_i = 1'b0;
    tick();
    uart_rx_i = 1'b1;
    entry     = cyc;
    wait_stage(3'd0, 300, n);
    checks++;
    if (stage !== 3'd0 || cyc - entry != int'(UartTo)) begin
      errors++;
      $display("FAIL spurious_return: got st%0d after %0d, want st0 after %0d", stage,
               cyc - entry, UartTo);
    end
    checks++;
    if ({m2_seen, vga_enable, uart_rx_enable} !== 3'b010) begin
      errors++;
      $display("FAIL spurious_outputs: got %b, want 010", {m2_seen, vga_enable, uart_rx_enable});
    end
  endtask

  task automatic test_skip_decode();
    int last_w, n;
    m2_seen     = 1'b0;
    skip_decode = 1'b1;
    start_load($urandom_range(1, 3), last_w);
    wait_stage(3'd0, 300, n);
    checks++;
    if (stage !== 3'd0 || cyc - last_w != int'(UartTo) || m2_seen !== 1'b0) begin
      errors++;
      $display("FAIL skip_decode: got st%0d after %0d m2=%b, want st0 after %0d m2=0", stage,
               cyc - last_w, m2_seen, UartTo);
    end
    skip_decode = 1'b0;
  endtask

  task automatic test_watchdog();
    int last_w, n, entry;
    start_load(1, last_w);
    wait_stage(3'd2, 300, n);
    entry = cyc;
    wait_stage(3'd4, 200, n);
    checks++;
    if (stage !== 3'd4 || cyc - entry != int'(StageTo) || {m2_start, error} !== 2'b01) begin
      errors++;
      $display("FAIL watchdog_abort: got st%0d after %0d start=%b err=%b, want st4 after %0d 0 1",
               stage, cyc - entry, m2_start, error, StageTo);
    end
    tick();
    checks++;
    if ({stage, vga_enable, error} !== {3'd0, 2'b11}) begin
      errors++;
      $display("FAIL abort_to_idle: got st%0d vga=%b err=%b, want st0 1 1", stage, vga_enable,
               error);
    end
    uart_rx_i = 1'b0;
    tick();
    uart_rx_i = 1'b1;
    checks++;
    if ({stage, error} !== {3'd1, 1'b0}) begin
      errors++;
      $display("FAIL error_clear: got st%0d err=%b, want st1 0", stage, error);
    end
    wait_stage(3'd0, 300, n);
  endtask

  task automatic test_done_vs_watchdog();
    int last_w, n;
    start_load(1, last_w);
    wait_stage(3'd2, 300, n);
    m2_done = 1'b1;
    tick();
    m2_done = 1'b0;
    checks++;
    if (stage !== 3'd3) begin
      errors++;
      $display("FAIL entry_cycle_done: got st%0d, want st3", stage);
    end
    repeat (StageTo - 1) tick();
    m1_done = 1'b1;
    tick();
    m1_done = 1'b0;
    checks++;
    if ({stage, error, vga_enable, m1_start} !== {3'd0, 3'b010}) begin
      errors++;
      $display("FAIL done_wins: got st%0d err=%b vga=%b m1=%b, want st0 0 1 0", stage, error,
               vga_enable, m1_start);
    end
  endtask

  task automatic test_reset_mid_m2();
    int last_w, n;
    start_load(1, last_w);
    wait_stage(3'd2, 300, n);
    repeat (3) tick();
    m2_we_n    = 1'b0;
    m2_address = 18'($urandom);
    #5;
    resetn = 1'b0;
    #1;
    checks++;
    if ({m2_start, vga_enable, stage, sram_we_n} !== {2'b01, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_m2: got start=%b vga=%b st%0d we_n=%b, want 0 1 st0 1",
               m2_start, vga_enable, stage, sram_we_n);
    end
    m2_we_n = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    checks++;
    if ({stage, vga_enable, error} !== {3'd0, 2'b10}) begin
      errors++;
      $display("FAIL post_reset_idle: got st%0d vga=%b err=%b, want st0 1 0", stage,
               vga_enable, error);
    end
  endtask

  initial begin
    test_reset();
    tick();
    test_idle_mux();
    test_load_decode();
    test_spurious();
    test_skip_decode();
    test_watchdog();
    test_done_vs_watchdog();
    test_reset_mid_m2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
